key_scan_pulse_gen: RTL and testbench
=====================================

// Module: key_scan_pulse_gen
// PURPOSE
// - Front-end for the button/up-down-counter/LED chain. Cyclically drives one-cold scan lines to the keys,
//   samples the shared active-low return line, debounces each key and emits single-cycle press pulses
//   (inc/dec/clear) to the downstream counter.
// - Optional hold-to-repeat. Replaces edge-clocked button logic: everything runs on clk.
// PARAMETERS
// - N_KEYS          3      number of scanned keys (= scan/pulse width), >= 2
// - SCAN_DIV        50000  clk cycles per scan slot, >= 4
// - DEBOUNCE_SCANS  8      consecutive differing samples needed to flip a key's level, >= 1
// - REPEAT_DELAY    50     frames held before first auto-repeat pulse; 0 = repeat disabled
// - REPEAT_RATE     10     frames between subsequent repeat pulses, >= 1
// PORTS
// - clk          in   1       system clock
// - rst          in   1       synchronous, active-high reset
// - i_sense      in   1       shared key return line, 0 = addressed key pressed; asynchronous
// - o_scan       out  N_KEYS  one-cold scan drive; bit k low = key k addressed
// - o_key_level  out  N_KEYS  debounced key state, 1 = pressed
// - o_key_pulse  out  N_KEYS  one-clk pulse per debounced press / repeat event
// BEHAVIOUR
// - Reset values: o_scan = ~1 (3'b110 at N_KEYS=3), o_key_level = 0, o_key_pulse = 0.
//   Reset also clears: divider, slot index, all debounce/repeat counters, synchronizer (to 1).
// - Sync: i_sense goes through 2-flop synchronizer (s_sense); no raw i_sense use.
// - Scan:
//   - div_cnt counts 0..SCAN_DIV-1.
//   - On wrap, slot advances 0..N_KEYS-1 and wraps to 0.
//   - o_scan = ~(1 << slot), registered.
//   - Frame = N_KEYS slots.
// - Sample point:
//   - Cycle with div_cnt == SCAN_DIV-1. Sample = ~s_sense for key[slot].
//   - This leaves >= 2 cycles settle + sync latency.
//   - Only key[slot] state updates that cycle.
// - Debounce (per key):
//   - cnt of width clog2(DEBOUNCE_SCANS+1).
//   - Sample == level: cnt <= 0.
//   - Sample != level: cnt++. When cnt would reach DEBOUNCE_SCANS, level toggles and cnt <= 0.
//   - No saturation overflow is possible.
// - Press pulse:
//   - A 0->1 level flip drives o_key_pulse[k] high for exactly the clk after the sample cycle.
//   - A 1->0 release gives no pulse.
// - Repeat (REPEAT_DELAY != 0):
//   - Per-key frame counter, cleared on the press pulse and on release.
//   - While level = 1, it is incremented at that key's sample point.
//   - Pulse when it reaches REPEAT_DELAY, then every REPEAT_RATE frames after.
//   - Counter holds at REPEAT_DELAY+REPEAT_RATE-1 before wrapping back to REPEAT_DELAY (no overflow).
// - Exclusivity:
//   - Keys sample in different slots, so at most one o_key_pulse bit is high per cycle.
//   - The downstream counter needs no priority logic.
// - Latency: a clean press steady from slot start gives level/pulse DEBOUNCE_SCANS frames later.
//   Pulse is 1 clk after that frame's sample cycle.
// - Multiple keys held: each debounces and repeats independently.
// - Reset mid-operation:
//   - Partial debounce is discarded; no pulse is emitted during or on exit from reset.
//   - A key held through reset is re-debounced and then produces one fresh press pulse.
// STRUCTURE
// - Package key_scan_pkg:
//   - N_KEYS.
//   - Key index constants KEY_INC=0, KEY_DEC=1, KEY_CLR=2.
//   - Default timing constants (SCAN_DIV, DEBOUNCE_SCANS, REPEAT_DELAY, REPEAT_RATE).
// - Sub-module key_debounce_ch, one generate instance per key.
//   - Inputs: clk, rst, sample_en, sample.
//   - Outputs: level, pulse.
//   - Holds the debounce cnt and repeat counter.
// - Top holds: synchronizer, divider, slot index, o_scan register.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2, N_KEYS=3; cycle 0 = first after rst drop)
// - Reset/scan: rst 2 clk then release -> o_scan 3'b110 cycles 0-3, 3'b101 4-7, 3'b011 8-11, 3'b110 at 12.
//   Outputs 0 throughout.
// - Clean press key0:
//   - Stimulus: i_sense low whenever o_scan[0]=0 (repeat disabled, REPEAT_DELAY=0).
//   - Samples at cycles 3, 15, 27.
//   - o_key_level[0]=1 and o_key_pulse[0]=1 at cycle 28 only; no further pulses while held.
// - Bounce: key1 sampled pressed/released alternately for 10 frames -> o_key_level[1] stays 0, no pulses.
//   Release after a press -> level 0 after 3 samples, no pulse.
// - Repeat:
//   - Stimulus: key2 held 12 frames.
//   - One press pulse, then repeat pulses 4 frames later and every 2 frames after.
//   - Each pulse is exactly 1 clk wide.
// - Multi-key: keys0 and 1 held together -> both levels 1; o_key_pulse never has >1 bit set in any cycle.
// - Reset mid-debounce:
//   - Stimulus: key0 held, rst pulsed after 2 samples (before level flip).
//   - No pulse around rst; after release, the pulse arrives 3 frames later.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared constants for the key scanner: key roles, default timing and a counter-width helper.
package key_scan_pkg;

  localparam int N_KEYS = 3;

  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_CLR = 2;

  localparam int SCAN_DIV_DEF       = 50000;
  localparam int DEBOUNCE_SCANS_DEF = 8;
  localparam int REPEAT_DELAY_DEF   = 50;
  localparam int REPEAT_RATE_DEF    = 10;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: debounces scan samples into a level and emits press / hold-repeat pulses.
module key_debounce_ch
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic sample,
  output logic level,
  output logic pulse
);

  localparam int CNT_W   = cnt_width(DEBOUNCE_SCANS + 1);
  localparam int REP_TOP = REPEAT_DELAY + REPEAT_RATE - 1;
  localparam int REP_W   = cnt_width(REP_TOP + 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [REP_W-1:0] rep, rep_nxt;
  logic             level_nxt;
  logic             pulse_nxt;

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt   = cnt;
    rep_nxt   = rep;
    level_nxt = level;
    pulse_nxt = 1'b0;
    if (sample_en) begin
      if (sample == level) begin
        cnt_nxt = '0;
      end else if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        level_nxt = ~level;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end

      // rep counts frames since the press; it parks in DELAY..DELAY+RATE-1 so it never overflows.
      if (level_nxt != level) begin
        rep_nxt   = '0;
        pulse_nxt = level_nxt;
      end else if (!level || REPEAT_DELAY == 0) begin
        rep_nxt = '0;
      end else begin
        rep_nxt   = (rep == REP_W'(REP_TOP)) ? REP_W'(REPEAT_DELAY) : rep + REP_W'(1);
        pulse_nxt = (rep_nxt == REP_W'(REPEAT_DELAY));
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rep   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rep   <= rep_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

endmodule

// File: rtl/key_scan_pulse_gen.sv
// Key-matrix front end: one-cold scan drive, synchronised shared return line, and one
// debounce/repeat channel per key producing single-cycle press pulses.
module key_scan_pulse_gen #(
  parameter int N_KEYS         = key_scan_pkg::N_KEYS,
  parameter int SCAN_DIV       = key_scan_pkg::SCAN_DIV_DEF,
  parameter int DEBOUNCE_SCANS = key_scan_pkg::DEBOUNCE_SCANS_DEF,
  parameter int REPEAT_DELAY   = key_scan_pkg::REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = key_scan_pkg::REPEAT_RATE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sense,
  output logic [N_KEYS-1:0] o_scan,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_KEYS-1:0] o_key_pulse
);

  localparam int DIV_W  = key_scan_pkg::cnt_width(SCAN_DIV);
  localparam int SLOT_W = key_scan_pkg::cnt_width(N_KEYS);

  logic              sense_meta;
  logic              s_sense;
  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic              sample_pt;

  // Synchroniser idles at 1 (no key pressed) so leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sense_meta <= 1'b1;
      s_sense    <= 1'b1;
    end else begin
      sense_meta <= i_sense;
      s_sense    <= sense_meta;
    end
  end

  // Sampling on the last cycle of a slot gives the scan line plus synchroniser time to settle.
  assign sample_pt = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign slot_nxt  = (slot == SLOT_W'(N_KEYS - 1)) ? '0 : slot + SLOT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= '0;
      o_scan  <= ~N_KEYS'(1);
    end else if (sample_pt) begin
      div_cnt <= '0;
      slot    <= slot_nxt;
      o_scan  <= ~(N_KEYS'(1) << slot_nxt);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : gen_ch
    key_debounce_ch #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_pt && (slot == SLOT_W'(k))),
      .sample    (~s_sense),
      .level     (o_key_level[k]),
      .pulse     (o_key_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_scan_pulse_gen.sv
// Bench: two scanners (repeat off / repeat on) on one physical key matrix, checked against an event-level model.
module tb_key_scan_pulse_gen;

  localparam int NK = 3;
  localparam int SD = 4;
  localparam int DS = 3;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] held = '0;
  logic          sense [2];
  logic [NK-1:0] scan  [2];
  logic [NK-1:0] level [2];
  logic [NK-1:0] pulse [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int dly [2] = '{0, 4};

  always #5 clk = ~clk;

  // Physical matrix: the return line is pulled low when any addressed key is held.
  assign sense[0] = ~|(held & ~scan[0]);
  assign sense[1] = ~|(held & ~scan[1]);

  key_scan_pulse_gen #(.N_KEYS(NK), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_DELAY(0), .REPEAT_RATE(RR))
    dut_norep (.clk(clk), .rst(rst), .i_sense(sense[0]), .o_scan(scan[0]),
               .o_key_level(level[0]), .o_key_pulse(pulse[0]));

  key_scan_pulse_gen #(.N_KEYS(NK), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_DELAY(4), .REPEAT_RATE(RR))
    dut_rep (.clk(clk), .rst(rst), .i_sense(sense[1]), .o_scan(scan[1]),
             .o_key_level(level[1]), .o_key_pulse(pulse[1]));

  // Reference model: per key, run length of disagreeing samples and frames held since the press.
  bit            smp;
  bit            m_lvl [2][NK];
  int            m_cnt [2][NK];
  int            m_frm [2][NK];
  logic [NK-1:0] m_pulse [2];

  function automatic logic [NK-1:0] m_level(input int i);
    logic [NK-1:0] r;
    for (int k = 0; k < NK; k++) r[k] = m_lvl[i][k];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = '0;
      for (int k = 0; k < NK; k++) begin
        m_lvl[i][k] = 1'b0;
        m_cnt[i][k] = 0;
        m_frm[i][k] = 0;
      end
    end
  endtask

  task automatic model_sample(input int k, input bit s);
    for (int i = 0; i < 2; i++) begin
      bit flip = 1'b0;
      if (s != m_lvl[i][k]) begin
        m_cnt[i][k]++;
        if (m_cnt[i][k] == DS) begin
          m_lvl[i][k] = s;
          m_cnt[i][k] = 0;
          flip = 1'b1;
        end
      end else begin
        m_cnt[i][k] = 0;
      end
      if (flip) begin
        m_frm[i][k]   = 0;
        m_pulse[i][k] = s;
      end else if (m_lvl[i][k]) begin
        m_frm[i][k]++;
        m_pulse[i][k] = (dly[i] != 0) && (m_frm[i][k] >= dly[i]) && ((m_frm[i][k] - dly[i]) % RR == 0);
      end
    end
  endtask

  // Advance one clock; the key seen at a sample point is what was held during the slot's second cycle.
  task automatic tick();
    int k;
    bit do_smp;
    k = (cyc / SD) % NK;
    if (cyc % SD == 1) smp = held[k];
    do_smp = (cyc % SD == SD - 1);
    @(posedge clk);
    #1;
    cyc++;
    m_pulse[0] = '0;
    m_pulse[1] = '0;
    if (do_smp) model_sample(k, smp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_clear();
  endtask

  task automatic test_reset();
    logic [NK-1:0] tbl [4];
    tbl = '{3'b110, 3'b101, 3'b011, 3'b110};
    held = '0;
    rst  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (scan[i] !== 3'b110 || level[i] !== '0 || pulse[i] !== '0) begin
          errors++;
          $display("FAIL reset_hold inst=%0d scan=%b level=%b pulse=%b want 110/000/000", i, scan[i], level[i], pulse[i]);
        end
      end
    end
    rst = 1'b0;
    cyc = 0;
    model_clear();
    for (int c = 0; c <= 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (scan[i] !== tbl[c / 4] || level[i] !== '0 || pulse[i] !== '0) begin
          errors++;
          $display("FAIL scan_seq inst=%0d cyc=%0d scan=%b want=%b level=%b pulse=%b", i, c, scan[i], tbl[c / 4], level[i], pulse[i]);
        end
      end
      if (c < 12) tick();
    end
  endtask

  task automatic test_clean_press();
    int n_pulse = 0;
    do_reset();
    held = 3'b001;
    for (int c = 0; c <= 48; c++) begin
      checks++;
      if (level[0][0] !== (c >= 28) || pulse[0] !== ((c == 28) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL clean_press cyc=%0d level=%b pulse=%b want level0=%0d pulse=%b", c, level[0], pulse[0], (c >= 28), (c == 28) ? 3'b001 : 3'b000);
      end
      checks++;
      if (level[1] !== m_level(1) || pulse[1] !== m_pulse[1]) begin
        errors++;
        $display("FAIL clean_press_rep cyc=%0d level=%b/%b pulse=%b/%b", c, level[1], m_level(1), pulse[1], m_pulse[1]);
      end
      n_pulse += int'(pulse[0][0] === 1'b1);
      tick();
    end
    checks++;
    if (n_pulse != 1) begin
      errors++;
      $display("FAIL clean_press_count got=%0d want=1", n_pulse);
    end
  endtask

  task automatic test_bounce();
    int rel_pulses = 0;
    do_reset();
    held = '0;
    for (int f = 0; f < 18; f++) begin
      if (f < 10) held[1] = (f % 2 == 0);
      else        held[1] = (f < 14);
      for (int c = 0; c < 12; c++) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (level[i] !== m_level(i) || pulse[i] !== m_pulse[i]) begin
            errors++;
            $display("FAIL bounce inst=%0d cyc=%0d level=%b/%b pulse=%b/%b", i, cyc, level[i], m_level(i), pulse[i], m_pulse[i]);
          end
          if (f < 10 && (level[i][1] !== 1'b0 || pulse[i] !== '0)) begin
            errors++;
            $display("FAIL bounce_quiet inst=%0d cyc=%0d level=%b pulse=%b want 0/0", i, cyc, level[i], pulse[i]);
          end
          if (f >= 14) rel_pulses += $countones(pulse[i]);
        end
        tick();
      end
      if (f == 13) begin
        checks++;
        if (level[0][1] !== 1'b1 || level[1][1] !== 1'b1) begin
          errors++;
          $display("FAIL bounce_steady level=%b,%b want key1=1", level[0], level[1]);
        end
      end
    end
    checks++;
    if (level[0][1] !== 1'b0 || level[1][1] !== 1'b0 || rel_pulses != 0) begin
      errors++;
      $display("FAIL bounce_release level=%b,%b pulses=%0d want key1=0 pulses=0", level[0], level[1], rel_pulses);
    end
  endtask

  task automatic test_repeat();
    int n_rep = 0, n_norep = 0, wide = 0;
    logic prev = 1'b0;
    do_reset();
    held = 3'b100;
    for (int c = 0; c < 12 * 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== m_level(i) || pulse[i] !== m_pulse[i]) begin
          errors++;
          $display("FAIL repeat inst=%0d cyc=%0d level=%b/%b pulse=%b/%b", i, cyc, level[i], m_level(i), pulse[i], m_pulse[i]);
        end
      end
      n_rep   += int'(pulse[1][2] === 1'b1);
      n_norep += int'(pulse[0][2] === 1'b1);
      wide    += int'(prev && pulse[1][2] === 1'b1);
      prev     = (pulse[1][2] === 1'b1);
      tick();
    end
    checks++;
    if (n_rep != 4 || n_norep != 1 || wide != 0) begin
      errors++;
      $display("FAIL repeat_count rep=%0d norep=%0d wide=%0d want 4/1/0", n_rep, n_norep, wide);
    end
    held = '0;
    repeat (4 * 12) tick();
  endtask

  task automatic test_multi_key();
    do_reset();
    held = 3'b011;
    for (int c = 0; c < 8 * 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== m_level(i) || pulse[i] !== m_pulse[i] || $countones(pulse[i]) > 1) begin
          errors++;
          $display("FAIL multi_key inst=%0d cyc=%0d level=%b/%b pulse=%b/%b", i, cyc, level[i], m_level(i), pulse[i], m_pulse[i]);
        end
      end
      tick();
    end
    checks++;
    if (level[0] !== 3'b011 || level[1] !== 3'b011) begin
      errors++;
      $display("FAIL multi_key_level got=%b,%b want=011", level[0], level[1]);
    end
    held = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    held = 3'b001;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== '0 || pulse[i] !== '0) begin
          errors++;
          $display("FAIL mid_pre inst=%0d cyc=%0d level=%b pulse=%b want 0/0", i, c, level[i], pulse[i]);
        end
      end
      tick();
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== '0 || pulse[i] !== '0 || scan[i] !== 3'b110) begin
          errors++;
          $display("FAIL mid_in_reset inst=%0d level=%b pulse=%b scan=%b want 000/000/110", i, level[i], pulse[i], scan[i]);
        end
      end
    end
    rst = 1'b0;
    cyc = 0;
    model_clear();
    for (int c = 0; c <= 40; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== ((c >= 28) ? 3'b001 : 3'b000) || pulse[i] !== ((c == 28) ? 3'b001 : 3'b000)) begin
          errors++;
          $display("FAIL mid_after inst=%0d cyc=%0d level=%b pulse=%b want level0=%0d pulse0=%0d", i, c, level[i], pulse[i], (c >= 28), (c == 28));
        end
      end
      tick();
    end
    held = '0;
  endtask

  task automatic test_random();
    do_reset();
    held = '0;
    for (int c = 0; c < 60 * 12; c++) begin
      if (cyc % SD == 0) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(5) == 0) held[k] = ~held[k];
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level[i] !== m_level(i) || pulse[i] !== m_pulse[i] || scan[i] !== ~(3'b001 << ((cyc / SD) % NK))) begin
          errors++;
          $display("FAIL random inst=%0d cyc=%0d level=%b/%b pulse=%b/%b scan=%b", i, cyc, level[i], m_level(i), pulse[i], m_pulse[i], scan[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_multi_key();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
